// File: rtl/scs8hd_scan_seq.sv
// Scan-chain sequencer for an scs8hd sdfrbp chain. Each run loads a
// CHAIN_LEN-bit pattern LSB first through SCD, spends one cycle with SCE low
// so the chain captures its functional inputs, then shifts the response out
// of SO into CAP_OUT. Bit j of CAP_OUT is the response of the cell loaded
// with bit j of the pattern.
module scs8hd_scan_seq #(
    parameter int   CHAIN_LEN = 16,
    parameter logic FILL      = 1'b0
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic [CHAIN_LEN-1:0] PAT_IN,
    input  logic                 SO,
    output logic                 SCE,
    output logic                 SCD,
    output logic [CHAIN_LEN-1:0] CAP_OUT,
    output logic                 BUSY,
    output logic                 DONE
);

    localparam int              CNT_W    = $clog2(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_CAPTURE = 2'd2,
        S_UNLOAD  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   sce_q, sce_d;
    logic                   scd_q, scd_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [CHAIN_LEN-1:0]   cap_out_q, cap_out_d;
    logic [CHAIN_LEN-1:0]   pat_sr_q, pat_sr_d;
    logic [CHAIN_LEN-1:0]   cap_sr_q, cap_sr_d;
    logic                   cnt_last;

    assign cnt_last = (cnt_q == CNT_LAST);

    // Next-state and next-output logic for the load/capture/unload sequence.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sce_d     = sce_q;
        scd_d     = scd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cap_out_d = cap_out_q;
        pat_sr_d  = pat_sr_q;
        cap_sr_d  = cap_sr_q;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    // First pattern bit goes out on SCD immediately so the
                    // first chain shift happens on the very next edge.
                    pat_sr_d = PAT_IN;
                    sce_d    = 1'b1;
                    scd_d    = PAT_IN[0];
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_LOAD;
                end
            end

            S_LOAD: begin
                pat_sr_d = pat_sr_q >> 1;
                if (cnt_last) begin
                    sce_d   = 1'b0;
                    scd_d   = 1'b0;
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    scd_d = pat_sr_q[1];
                end
            end

            S_CAPTURE: begin
                // The chain takes its functional D on this edge; shifting
                // resumes right after, refilling the chain with FILL.
                sce_d   = 1'b1;
                scd_d   = FILL;
                cnt_d   = '0;
                state_d = S_UNLOAD;
            end

            S_UNLOAD: begin
                // SO already holds the next captured bit before the edge;
                // the first bit out belongs to the cell loaded with PAT[0].
                cap_sr_d = {SO, cap_sr_q[CHAIN_LEN-1:1]};
                if (cnt_last) begin
                    cap_out_d = cap_sr_d;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    sce_d     = 1'b0;
                    scd_d     = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and output registers; reset aborts any run and clears CAP_OUT.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sce_q     <= 1'b0;
            scd_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cap_out_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sce_q     <= sce_d;
            scd_q     <= scd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cap_out_q <= cap_out_d;
        end
    end

    // Working shift registers; every run fully rewrites them before use.
    always_ff @(posedge CLK) begin
        pat_sr_q <= pat_sr_d;
        cap_sr_q <= cap_sr_d;
    end

    assign SCE     = sce_q;
    assign SCD     = scd_q;
    assign CAP_OUT = cap_out_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;

endmodule
